// File: rtl/stream_demux_n.sv
// N-way valid/ready demultiplexer: each input beat is steered by in_sel into a
// one-entry per-channel output slot; out-of-range selects are dropped and counted.
module stream_demux_n #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned NUM_CH_U = NUM_CH;

  logic [NUM_CH-1:0] slot_v_q, slot_v_d;
  logic [DATA_W-1:0] slot_d_q [NUM_CH];
  logic [DATA_W-1:0] slot_d_d [NUM_CH];
  logic              sel_err_q, sel_err_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              sel_ok;
  logic [NUM_CH-1:0] sel_hit;
  logic              accept;

  always_comb begin
    sel_ok  = 32'(in_sel) < NUM_CH_U;
    sel_hit = '0;
    for (int unsigned k = 0; k < NUM_CH_U; k++) begin
      sel_hit[k] = sel_ok && (in_sel == SEL_W'(k));
    end
    // Dropped beats are always accepted; steered beats need room or a draining slot.
    in_ready = !sel_ok || (|(sel_hit & (~slot_v_q | out_ready)));
    accept   = in_valid && in_ready;

    slot_v_d = slot_v_q & ~out_ready;
    slot_d_d = slot_d_q;
    for (int unsigned k = 0; k < NUM_CH_U; k++) begin
      if (accept && sel_hit[k]) begin
        slot_v_d[k] = 1'b1;
        slot_d_d[k] = in_data;
      end
    end

    sel_err_d  = accept && !sel_ok;
    drop_cnt_d = drop_cnt_q;
    if (sel_err_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q   <= '0;
      sel_err_q  <= 1'b0;
      drop_cnt_q <= '0;
      for (int unsigned k = 0; k < NUM_CH_U; k++) begin
        slot_d_q[k] <= '0;
      end
    end else begin
      slot_v_q   <= slot_v_d;
      slot_d_q   <= slot_d_d;
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Slot data is not cleared on drain, so idle channels are masked to zero here.
  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < NUM_CH_U; k++) begin
      out_data[k*DATA_W +: DATA_W] = slot_v_q[k] ? slot_d_q[k] : '0;
    end
  end

  assign out_valid = slot_v_q;
  assign sel_err   = sel_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n: a 4-channel instance for steering and
// a 3-channel instance for out-of-range drop handling.
module tb_stream_demux_n;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = '0;
  logic         sel_err;
  logic [7:0]   drop_cnt;

  logic [31:0]  in_data3 = '0;
  logic [1:0]   in_sel3 = '0;
  logic         in_valid3 = 1'b0;
  logic         in_ready3;
  logic [95:0]  out_data3;
  logic [2:0]   out_valid3;
  logic [2:0]   out_ready3 = 3'b111;
  logic         sel_err3;
  logic [7:0]   drop_cnt3;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [4][$];

  always #5 clk = ~clk;

  stream_demux_n #(.DATA_W(32), .NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .drop_cnt(drop_cnt)
  );

  stream_demux_n #(.DATA_W(32), .NUM_CH(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3),
    .drop_cnt(drop_cnt3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every beat that completes a handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_beat_ch%0d", k), 64'(out_data[k*32 +: 32]), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk($sformatf("beat_ch%0d", k), 64'(out_data[k*32 +: 32]), 64'(exp_q[k].pop_front()));
          end
        end else if (!out_valid[k]) begin
          chk($sformatf("idle_zero_ch%0d", k), 64'(out_data[k*32 +: 32]), 64'd0);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] s);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q[s].push_back(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data_zero", 64'(out_data == '0), 64'd1);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk($sformatf("rst_in_ready_sel%0d", s), 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;

    // Single steer
    out_ready = 4'b1111;
    send(32'hDEAD_BEEF, 2'd2);
    @(negedge clk);
    chk("steer_valid", 64'(out_valid), 64'b0100);
    chk("steer_ch2", 64'(out_data[64 +: 32]), 64'hDEAD_BEEF);
    chk("steer_ch0", 64'(out_data[0 +: 32]), 64'd0);
    @(negedge clk);
    chk("steer_drained", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Backpressure on ch1; ch3 proceeds independently
    out_ready = 4'b1101;
    send(32'h11, 2'd1);
    in_data = 32'h22; in_sel = 2'd1; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_ch1_held", 64'(out_data[32 +: 32]), 64'h11);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    send(32'h33, 2'd3);
    @(negedge clk);
    chk("bp_ch3_valid", 64'(out_valid), 64'b1010);
    chk("bp_ch3_data", 64'(out_data[96 +: 32]), 64'h33);
    chk("bp_ch1_still", 64'(out_data[32 +: 32]), 64'h11);
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    send(32'h22, 2'd1);
    @(negedge clk);
    chk("bp_ch1_second", 64'(out_data[32 +: 32]), 64'h22);
    @(posedge clk); #1;

    // Full throughput on ch0
    out_ready = 4'b1111;
    in_valid = 1'b1;
    in_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i);
      @(negedge clk);
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("tp_valid_continuous", 64'(out_valid[0]), 64'd1);
      exp_q[0].push_back(32'(i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("tp_sel_err_never", 64'(sel_err), 64'd0);

    // Out-of-range on the 3-channel instance: 300 dropped beats
    in_sel3 = 2'd3; in_data3 = 32'hBAD0_0000; in_valid3 = 1'b1;
    #1 chk("oor_in_ready", 64'(in_ready3), 64'd1);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 300) in_valid3 = 1'b0;
      @(negedge clk);
      chk("oor_sel_err", 64'(sel_err3), 64'd1);
      chk("oor_drop_cnt", 64'(drop_cnt3), 64'((i > 255) ? 255 : i));
      chk("oor_no_valid", 64'(out_valid3), 64'd0);
      if (i < 300) chk("oor_in_ready_run", 64'(in_ready3), 64'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_sel_err_end", 64'(sel_err3), 64'd0);
    chk("oor_drop_cnt_hold", 64'(drop_cnt3), 64'd255);

    // Asynchronous reset with held beats
    @(posedge clk); #1;
    out_ready = 4'b0000;
    send(32'hA0, 2'd0);
    send(32'hA1, 2'd1);
    @(negedge clk);
    chk("rm_loaded", 64'(out_valid), 64'b0011);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rm_valid_cleared", 64'(out_valid), 64'd0);
    chk("rm_data_cleared", 64'(out_data == '0), 64'd1);
    chk("rm_drop_cnt3_cleared", 64'(drop_cnt3), 64'd0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    send(32'h5A5A_0001, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sb_empty_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
